// File: rtl/condicionador_botoes.sv
// condicionador_botoes: 4-button synchronizer, debouncer and one-hot play capture.
// Define CONDICIONADOR_ERRO_MULTIPLO_EN to flag rejected multi-button presses.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       erro_multiplo,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'b000,
    FILTRANDO     = 3'b001,
    REGISTRA      = 3'b010,
    ESPERA_SOLTAR = 3'b011
  } estado_t;

  localparam logic [7:0] CNT_FIM = 8'(DEBOUNCE_CYCLES - 1);

  estado_t    estado;
  logic [3:0] sync1;
  logic [3:0] sync;
  logic [3:0] candidato;
  logic [7:0] cnt;
  logic       um_quente;
  logic       erro_q;

  assign um_quente = (candidato != 4'd0) &&
                     ((candidato & (candidato - 4'd1)) == 4'd0);

  assign db_estado = estado;

`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
  assign erro_multiplo = erro_q;
`else
  assign erro_multiplo = 1'b0;
`endif

  // Pulses are set on the edge entering REGISTRA so they are high
  // exactly while the FSM sits in REGISTRA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      sync1      <= 4'd0;
      sync       <= 4'd0;
      candidato  <= 4'd0;
      cnt        <= 8'd0;
      jogada     <= 4'd0;
      tem_jogada <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      sync1      <= botoes;
      sync       <= sync1;
      tem_jogada <= 1'b0;
      erro_q     <= 1'b0;
      if (limpa)
        jogada <= 4'd0;
      case (estado)
        OCIOSO: begin
          if (sync != 4'd0 && habilita) begin
            candidato <= sync;
            cnt       <= 8'd0;
            estado    <= FILTRANDO;
          end
        end
        FILTRANDO: begin
          if (sync == 4'd0) begin
            estado <= OCIOSO;
          end else if (sync != candidato) begin
            candidato <= sync;
            cnt       <= 8'd0;
          end else if (cnt == CNT_FIM) begin
            estado     <= REGISTRA;
            tem_jogada <= um_quente;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
            erro_q     <= !um_quente;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        REGISTRA: begin
          if (um_quente && !limpa)
            jogada <= candidato;
          cnt    <= 8'd0;
          estado <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (sync != 4'd0) begin
            cnt <= 8'd0;
          end else if (cnt == CNT_FIM) begin
            cnt    <= 8'd0;
            estado <= OCIOSO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes: directed vectors and corner sequences
// for the button conditioner with default DEBOUNCE_CYCLES = 4.
module tb_condicionador_botoes;

`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       clock;
  logic       reset;
  logic       habilita;
  logic       limpa;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       erro_multiplo;
  logic [2:0] db_estado;

  condicionador_botoes #(.DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .limpa         (limpa),
    .botoes        (botoes),
    .jogada        (jogada),
    .tem_jogada    (tem_jogada),
    .erro_multiplo (erro_multiplo),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] b;
    logic       hab;
    logic       lim;
    int         n;
    int         exp_tem;
    int         exp_err;
    logic [3:0] exp_jog;
    bit         chk_idle;
  } vec_t;

  vec_t vecs[6];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_tem  = 0;
  int n_err  = 0;
  int n_busy = 0;
  int viol   = 0;
  logic prev_t = 1'b0;
  logic prev_e = 1'b0;

  // Pulse shape checks: never two cycles in a row, never both at once.
  always @(negedge clock) begin
    if (reset) begin
      if (tem_jogada && prev_t) viol++;
      if (erro_multiplo && prev_e) viol++;
      if (tem_jogada && erro_multiplo) viol++;
    end
    prev_t = tem_jogada;
    prev_e = erro_multiplo;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (tem_jogada) n_tem++;
    if (erro_multiplo) n_err++;
    if (db_estado != 3'd0) n_busy++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_tem  = 0;
    n_err  = 0;
    n_busy = 0;
  endtask

  // Clean press with edge-exact latency check; caller is 1 time unit past a posedge.
  task automatic press(input string name, input logic [3:0] b);
    clear_counts();
    botoes = b;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == 5) chk({name, "_pre"}, int'(tem_jogada), 0);
      if (e == 6) chk({name, "_edge6"}, int'(tem_jogada), 1);
      if (e == 7) chk({name, "_post"}, int'(tem_jogada), 0);
    end
    botoes = 4'd0;
    for (int e = 10; e < 16; e++) begin
      tick();
      if (e == 14) chk({name, "_wait"}, int'(db_estado), 3);
      if (e == 15) chk({name, "_idle"}, int'(db_estado), 0);
    end
    chk({name, "_pulses"}, n_tem, 1);
    chk({name, "_jogada"}, int'(jogada), int'(b));
  endtask

  initial begin
    vecs[0] = '{4'b0011, 1'b1, 1'b0, 10,   0, ERR_EN, 4'b0100, 1'b0};
    vecs[1] = '{4'b1000, 1'b1, 1'b0, 3500, 1, 0,      4'b1000, 1'b0};
    vecs[2] = '{4'b0010, 1'b0, 1'b0, 10,   0, 0,      4'b1000, 1'b1};
    vecs[3] = '{4'b0100, 1'b1, 1'b0, 10,   1, 0,      4'b0100, 1'b0};
    vecs[4] = '{4'b1111, 1'b1, 1'b0, 10,   0, ERR_EN, 4'b0100, 1'b0};
    vecs[5] = '{4'b0001, 1'b1, 1'b1, 10,   1, 0,      4'b0000, 1'b0};

    reset    = 1'b0;
    habilita = 1'b1;
    limpa    = 1'b0;
    botoes   = 4'd0;
    #12;
    chk("rst_jogada", int'(jogada), 0);
    chk("rst_tem", int'(tem_jogada), 0);
    chk("rst_erro", int'(erro_multiplo), 0);
    chk("rst_estado", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    press("clean", 4'b0001);

    // Bounce: 0100/0000 toggling, then stable.
    clear_counts();
    botoes = 4'b0100; tick();
    botoes = 4'b0000; tick();
    botoes = 4'b0100; tick();
    chk("bounce_quiet", n_tem, 0);
    run(10);
    botoes = 4'd0;
    run(8);
    chk("bounce_pulses", n_tem, 1);
    chk("bounce_jogada", int'(jogada), 4);

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      botoes   = vecs[i].b;
      habilita = vecs[i].hab;
      limpa    = vecs[i].lim;
      run(vecs[i].n);
      if (vecs[i].chk_idle) chk($sformatf("v%0d_idle", i), n_busy, 0);
      botoes   = 4'd0;
      habilita = 1'b1;
      limpa    = 1'b0;
      run(8);
      chk($sformatf("v%0d_tem", i), n_tem, vecs[i].exp_tem);
      chk($sformatf("v%0d_err", i), n_err, vecs[i].exp_err);
      chk($sformatf("v%0d_jogada", i), int'(jogada), int'(vecs[i].exp_jog));
      chk($sformatf("v%0d_estado", i), int'(db_estado), 0);
    end

    // Async reset while filtering.
    clear_counts();
    botoes = 4'b0001;
    run(4);
    chk("arst_filtering", int'(db_estado), 1);
    #2;
    reset  = 1'b0;
    botoes = 4'd0;
    #1;
    chk("arst_estado", int'(db_estado), 0);
    chk("arst_tem", int'(tem_jogada), 0);
    chk("arst_jogada", int'(jogada), 0);
    #4;
    reset = 1'b1;
    tick();
    run(8);
    chk("arst_no_pulse", n_tem, 0);
    press("after_rst", 4'b0001);

    // limpa in the REGISTRA cycle.
    clear_counts();
    botoes = 4'b0010;
    run(7);
    chk("limpa_tem", int'(tem_jogada), 1);
    chk("limpa_registra", int'(db_estado), 2);
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    chk("limpa_jogada", int'(jogada), 0);
    botoes = 4'd0;
    run(10);
    chk("limpa_pulses", n_tem, 1);
    chk("limpa_jogada_end", int'(jogada), 0);
    chk("limpa_estado", int'(db_estado), 0);

    chk("pulse_shape", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable cycles required before a press or release is accepted (legal range 2..255).
REQ-002 The block SHALL have port clock  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have port habilita  input  1  high permits acceptance of a new press.
REQ-005 The block SHALL have port limpa  input  1  synchronous clear of the jogada register.
REQ-006 The block SHALL have port botoes  input  4  raw, asynchronous player buttons.
REQ-007 The block SHALL have port jogada  output  4  last accepted one-hot play.
REQ-008 The block SHALL have port tem_jogada  output  1  one-cycle pulse when a play is accepted.
REQ-009 The block SHALL have port erro_multiplo  output  1  one-cycle pulse when a multi-button press is rejected.
REQ-010 The block SHALL have port db_estado  output  3  current FSM state code.

Function
REQ-011 botoes SHALL pass through a 2-flop synchronizer; "sync" below denotes the second flop's output.
REQ-012 The FSM SHALL have states OCIOSO=000, FILTRANDO=001, REGISTRA=010, ESPERA_SOLTAR=011; the unused codes SHALL go to OCIOSO on the next edge.
REQ-013 OCIOSO: if sync!=0 and habilita=1, the FSM SHALL load candidate<=sync, cnt<=0 and go to FILTRANDO; otherwise it SHALL stay in OCIOSO.
REQ-014 FILTRANDO, sync==0: the FSM SHALL go to OCIOSO and treat the press as a glitch (no pulse).
REQ-015 FILTRANDO, sync!=0 and sync!=candidate: the FSM SHALL set candidate<=sync, set cnt<=0 and stay in FILTRANDO.
REQ-016 FILTRANDO, sync==candidate: if cnt==DEBOUNCE_CYCLES-1 the FSM SHALL go to REGISTRA, else it SHALL increment cnt (8-bit, never wraps).
REQ-017 REGISTRA SHALL last exactly one cycle; if candidate is one-hot, tem_jogada=1 and jogada<=candidate at the exiting edge; in all cases the next state SHALL be ESPERA_SOLTAR.
REQ-018 ESPERA_SOLTAR SHALL count consecutive cycles with sync==0, restart the count on any sync!=0, and go to OCIOSO after DEBOUNCE_CYCLES zero cycles.
REQ-019 Latency: with edge 0 being the edge that first samples a new stable botoes value into the synchronizer, tem_jogada SHALL be high during the cycle after edge DEBOUNCE_CYCLES+2 (edge 6 for default 4).
REQ-020 tem_jogada and erro_multiplo SHALL be Moore outputs of REGISTRA, never high for 2 consecutive cycles, and never both high.
REQ-021 habilita SHALL gate only OCIOSO->FILTRANDO; a press already in FILTRANDO or later SHALL complete regardless of habilita.
REQ-022 limpa=1 SHALL force jogada<=0 on that edge, taking priority over a simultaneous REGISTRA load, while the tem_jogada pulse still occurs.
REQ-023 Holding a button for any duration SHALL yield exactly one tem_jogada; a new press SHALL require passing through ESPERA_SOLTAR.

Reset
REQ-024 reset=0 SHALL asynchronously set the state to OCIOSO and set jogada=0000, tem_jogada=0, erro_multiplo=0, cnt=0, candidate=0, both synchronizer flops=0, and db_estado=000.
REQ-025 Reset asserted mid-press SHALL discard the press with no pulse; after release the block SHALL need a full DEBOUNCE_CYCLES filter again.

Configuration
REQ-026 With macro CONDICIONADOR_ERRO_MULTIPLO_EN defined, REGISTRA with a non-one-hot candidate SHALL pulse erro_multiplo for one cycle, leaving jogada unchanged.
REQ-027 Without CONDICIONADOR_ERRO_MULTIPLO_EN, erro_multiplo SHALL be tied to 0 and non-one-hot presses SHALL be silently ignored, with the FSM path unchanged.

Verification
REQ-028 The bench SHALL cover clean press: reset, habilita=1, botoes=0001 for 10 cycles then 0000 -> one tem_jogada pulse at edge 6, jogada=0001, FSM back in OCIOSO 4 cycles after sync returns to 0.
REQ-029 The bench SHALL cover bounce: botoes toggling 0100/0000 every cycle for 3 cycles, then 0100 stable for 10 cycles -> exactly one pulse, jogada=0100, no pulse during bouncing.
REQ-030 The bench SHALL cover a multiple press: botoes=0011 for 10 cycles -> with the macro, one erro_multiplo pulse and jogada unchanged; without it, no pulses.
REQ-031 The bench SHALL cover long hold and habilita: botoes=1000 held 3500 cycles -> exactly one pulse. Then habilita=0 with botoes=0010 for 10 cycles -> no pulse, state stays 000.
REQ-032 The bench SHALL cover async reset mid-press: reset=0 for half a cycle while in FILTRANDO -> outputs zero immediately, no pulse; a subsequent clean 0001 press -> normal pulse.
REQ-033 The bench SHALL cover limpa collision: limpa=1 in the REGISTRA cycle -> tem_jogada=1, jogada=0000 afterward.
